bank_rr_arbiter: RTL

BANK_RR_ARBITER -- requirements
Module: bank_rr_arbiter

---
 rtl/bank_rr_arbiter_pkg.sv | 15 +
 rtl/bank_rr_arbiter_rr_prio_pick.sv | 28 ++
 rtl/bank_rr_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/bank_rr_arbiter_pkg.sv
// Shared definitions for the bank arbiter: FIFO entry field layout and FSM encodings.
// The same layout is used by the PE request FIFOs (synch_fifo).
package bank_rr_arbiter_pkg;
    localparam int BANK_ID_MSB = 35;
    localparam int BANK_ID_LSB = 32;
    localparam int PAYLOAD_W   = 32;
    localparam int PTR_W       = 4;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;
endpackage

// File: rtl/bank_rr_arbiter_rr_prio_pick.sv
// Rotating-priority search: first set request at or after i_rr_ptr, wrapping modulo PE_NUM.
module rr_prio_pick
    import bank_rr_arbiter_pkg::*;
#(
    parameter int PE_NUM = 16
) (
    input  logic [PE_NUM-1:0] i_req,
    input  logic [PTR_W-1:0]  i_rr_ptr,
    output logic [PE_NUM-1:0] o_gnt,
    output logic [PTR_W-1:0]  o_idx,
    output logic              o_any
);
    always_comb begin
        int pos;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        pos   = 0;
        for (int k = 0; k < PE_NUM; k++) begin
            pos = (int'(i_rr_ptr) + k) % PE_NUM;
            if (!o_any && i_req[pos]) begin
                o_any      = 1'b1;
                o_gnt[pos] = 1'b1;
                o_idx      = PTR_W'(pos);
            end
        end
    end
endmodule

// File: rtl/bank_rr_arbiter.sv
// Round-robin arbiter for one memory bank: pops one PE FIFO head per ready cycle
// and registers the granted access toward the bank.
module bank_rr_arbiter
    import bank_rr_arbiter_pkg::*;
#(
    parameter int PE_NUM     = 16,
    parameter int FIFO_WIDTH = 36,
    parameter int BANK_ID    = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [PE_NUM-1:0]            req,
    input  logic [PE_NUM*FIFO_WIDTH-1:0] req_data,
    input  logic                         bank_ready,
    output logic [PE_NUM-1:0]            nxt_gnt,
    output logic                         bank_en,
    output logic [PAYLOAD_W-1:0]         bank_data,
    output logic [PTR_W-1:0]             bank_pe_id,
    output logic                         req_err,
    output logic [CNT_W-1:0]             gnt_cnt
);
    arb_state_t r_state, w_state_nxt;
    logic [PTR_W-1:0]     r_rr_ptr;
    logic                 r_bank_en;
    logic [PAYLOAD_W-1:0] r_bank_data;
    logic [PTR_W-1:0]     r_bank_pe_id;
    logic                 r_req_err;
    logic [CNT_W-1:0]     r_gnt_cnt;

    logic [PE_NUM-1:0]                  w_pick_gnt;
    logic [PTR_W-1:0]                   w_idx;
    logic                               w_any;
    logic                               w_gnt_vld;
    logic [PE_NUM-1:0][FIFO_WIDTH-1:0]  w_entries;
    logic [FIFO_WIDTH-1:0]              w_sel;
    logic                               w_bad_id;
    logic [PTR_W-1:0]                   w_ptr_nxt;

    rr_prio_pick #(.PE_NUM(PE_NUM)) u_pick (
        .i_req    (req),
        .i_rr_ptr (r_rr_ptr),
        .o_gnt    (w_pick_gnt),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    assign w_entries = req_data;
    assign w_sel     = w_entries[w_idx];
    assign w_bad_id  = w_sel[BANK_ID_MSB:BANK_ID_LSB] != PTR_W'(BANK_ID);
    assign w_ptr_nxt = (w_idx == PTR_W'(PE_NUM - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (req != '0) w_state_nxt = ST_ARB;
            ST_ARB: begin
                if (req == '0)       w_state_nxt = ST_IDLE;
                else if (!bank_ready) w_state_nxt = ST_STALL;
            end
            ST_STALL: if (bank_ready) w_state_nxt = ST_ARB;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Grants only come out of ARB; reset forces IDLE, so nxt_gnt is zero during reset too.
    always_comb begin
        w_gnt_vld = (r_state == ST_ARB) && bank_ready && w_any;
        nxt_gnt   = w_gnt_vld ? w_pick_gnt : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr     <= '0;
            r_bank_en    <= 1'b0;
            r_bank_data  <= '0;
            r_bank_pe_id <= '0;
            r_req_err    <= 1'b0;
            r_gnt_cnt    <= '0;
        end else begin
            r_bank_en <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_rr_ptr     <= w_ptr_nxt;
                r_bank_data  <= w_sel[PAYLOAD_W-1:0];
                r_bank_pe_id <= w_idx;
                if (w_bad_id) r_req_err <= 1'b1;
                if (r_gnt_cnt != {CNT_W{1'b1}}) r_gnt_cnt <= r_gnt_cnt + 1'b1;
            end
        end
    end

    assign bank_en    = r_bank_en;
    assign bank_data  = r_bank_data;
    assign bank_pe_id = r_bank_pe_id;
    assign req_err    = r_req_err;
    assign gnt_cnt    = r_gnt_cnt;
endmodule
